tetris_bag_scheduler: RTL and testbench
=======================================

# tetris_bag_scheduler

- Hardware "7-bag" piece scheduler for the Tetris sequencer peripheral.
- Draws tetromino IDs from a 16-bit LFSR without replacement: each bag of 7 contains every piece exactly once.
- Keeps a preview queue full and hands pieces to the game datapath over a valid/ready handshake.
- Raises a sticky bag-refill interrupt for the AXI-Lite interrupt controller.

## Interface
Parameters:
- PREVIEW_DEPTH, 4: preview queue entries; legal range 1–8.
- LFSR_SEED, 16'hACE1: LFSR value after reset. Also substituted whenever a zero seed is loaded.
- MAX_REJECTS, 8: rejected draws allowed before the fallback pick.

Ports:
- ACLK  in  1  sole clock, rising edge.
- ARESET  in  1  reset; synchronous, active-high.
- enable  in  1  allows drawing; when low, the FSM parks in IDLE after finishing its current push.
- seed_load  in  1  one-cycle strobe.
  - Loads seed into the LFSR.
  - Clears the bag and the queue.
  - FSM goes to IDLE.
- seed  in  16  seed value.
- piece_valid  out  1  queue head valid.
- piece_ready  in  1  consumer accepts the head.
- piece_id  out  3  queue head ID, 0–6 = I,O,T,S,Z,J,L.
- preview  out  3*PREVIEW_DEPTH  queue contents. Entry k is bits [3k+2:3k], entry 0 is the head; unused entries read 0.
- preview_count  out  4  number of valid entries.
- bag_remaining  out  3  pieces still undrawn in the current bag.
- irq  out  1  sticky bag-refill interrupt.
- irq_ack  in  1  clears irq.

## Operation
- State: bag mask (7 bits, 1 = undrawn), LFSR, reject counter, queue, FSM.
- FSM states: IDLE, DRAW, PUSH.
  - IDLE → DRAW when enable=1 and the queue is not full.
  - DRAW, one candidate per cycle. The LFSR steps every DRAW cycle; candidate = lfsr[2:0] taken before the step.
    - If the mask is all zero: refill the mask to 7'h7F, set irq, stay in DRAW. This takes 1 cycle and consumes no LFSR step.
    - Accept the candidate if it is < 7 and its mask bit is set. Otherwise increment the reject counter.
    - When the reject counter reaches MAX_REJECTS, the next DRAW cycle takes the lowest-index set mask bit instead.
    - On accept: clear the mask bit, reset the reject counter, latch the ID, go to PUSH.
  - PUSH: write the ID at tail position preview_count, or preview_count-1 if a pop happens in the same cycle.
    - Next state is DRAW if enable=1 and the queue will still not be full, else IDLE.
- Pop: piece_valid && piece_ready shifts the queue down by one entry.
- Simultaneous push and pop on a full queue is legal; count is unchanged.
- Push is never attempted into a full queue without a pop, because the FSM checks fullness before leaving IDLE or PUSH.
- irq: set on refill; cleared on irq_ack. If set and ack coincide, set wins.
- The first refill after reset also sets irq, since the mask starts empty.
- seed_load has priority over every other update except ARESET.
- bag_remaining = popcount(mask).
- LFSR: Galois, right shift, taps 16'hB400. It never holds zero.

## Timing
- Reset values:
  - LFSR = LFSR_SEED.
  - mask = 0, queue = 0, preview_count = 0.
  - piece_valid = 0, piece_id = 0, preview = 0.
  - bag_remaining = 0, irq = 0.
  - FSM = IDLE.
- All outputs are registered except piece_id, piece_valid and bag_remaining, which are combinational decodes of registers.
- Draw latency from DRAW entry to queue write: minimum 2 cycles (DRAW, PUSH); maximum MAX_REJECTS+3, including one refill cycle.
- Pop takes effect on the same edge piece_ready is sampled high. piece_valid deasserts the following cycle if the queue becomes empty.
- ARESET or seed_load during DRAW or PUSH abandons the in-flight piece. No partial write occurs.
- The consumer may hold piece_ready high continuously. Throughput is then bounded by draw latency.

## Structure
- Package tetris_seq_pkg holds:
  - piece_t enum (I=0 … L=6)
  - NUM_PIECES=7
  - LFSR_TAPS=16'hB400
  - the bag-scheduler FSM state enum
- Sub-module tetris_lfsr16 has ports:
  - ACLK, ARESET
  - step, load, load_value
  - state output
- It carries the zero-seed substitution.
- Everything else stays in one module.

## Test plan
- Reset, then enable=1 with piece_ready=0 → within 4·(MAX_REJECTS+3)+1 cycles, preview_count=4 and irq=1. bag_remaining=3.
- piece_ready=1 continuously for 70 pops → every aligned group of 7 pops contains IDs 0–6 exactly once. irq re-asserts once per bag after each irq_ack.
- seed_load with seed=16'h1234 twice, separated by 20 pops → the identical 20-piece sequence repeats. Loading seed=0 reproduces the LFSR_SEED sequence from reset.
- Force a reject streak by seed choice, or check with the scoreboard model → the fallback pick equals the lowest remaining ID, and it arrives at exactly MAX_REJECTS+1 DRAW cycles.
- Queue full with pop and push in the same cycle → preview_count stays 4, old entry 1 becomes the head, and the new ID lands in entry 3.
- ARESET asserted mid-DRAW, and irq_ack coincident with a refill → all outputs return to their reset values; irq stays 1 in the coincident case.

Source files
------------

// File: rtl/tetris_seq_pkg.sv
// rtl/tetris_seq_pkg.sv - shared piece, LFSR and bag-scheduler definitions
package tetris_seq_pkg;

    typedef enum logic [2:0] {
        PIECE_I = 3'd0,
        PIECE_O = 3'd1,
        PIECE_T = 3'd2,
        PIECE_S = 3'd3,
        PIECE_Z = 3'd4,
        PIECE_J = 3'd5,
        PIECE_L = 3'd6
    } piece_t;

    localparam int          NUM_PIECES = 7;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    typedef enum logic [1:0] {
        BAG_IDLE = 2'd0,
        BAG_DRAW = 2'd1,
        BAG_PUSH = 2'd2
    } bag_state_t;

    function automatic logic [2:0] lowest_set(input logic [6:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_PIECES - 1; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [2:0] popcount7(input logic [6:0] m);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < NUM_PIECES; i++) begin
            c = c + {2'd0, m[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/tetris_lfsr16.sv
// rtl/tetris_lfsr16.sv - 16-bit Galois LFSR, right shift, with zero-seed substitution
module tetris_lfsr16
    import tetris_seq_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        step,
    input  logic        load,
    input  logic [15:0] load_value,
    output logic [15:0] state
);

    // A zero load would lock the register at zero forever, so it maps to SEED.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= SEED;
        end else if (load) begin
            state <= (load_value == 16'd0) ? SEED : load_value;
        end else if (step) begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/tetris_bag_scheduler.sv
// rtl/tetris_bag_scheduler.sv - 7-bag piece scheduler with preview queue and refill irq
module tetris_bag_scheduler
    import tetris_seq_pkg::*;
#(
    parameter int          PREVIEW_DEPTH = 4,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          MAX_REJECTS   = 8
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic                         enable,
    input  logic                         seed_load,
    input  logic [15:0]                  seed,
    output logic                         piece_valid,
    input  logic                         piece_ready,
    output logic [2:0]                   piece_id,
    output logic [3*PREVIEW_DEPTH-1:0]   preview,
    output logic [3:0]                   preview_count,
    output logic [2:0]                   bag_remaining,
    output logic                         irq,
    input  logic                         irq_ack
);

    localparam int         RW     = $clog2(MAX_REJECTS + 1);
    localparam logic [3:0] DEPTH4 = 4'(PREVIEW_DEPTH);

    bag_state_t    state, state_nx;
    logic [6:0]    mask;
    logic [RW-1:0] rej_cnt;
    logic [2:0]    latched_id;
    logic [2:0]    q    [PREVIEW_DEPTH];
    logic [2:0]    q_nx [PREVIEW_DEPTH];
    logic [3:0]    count, count_nx, wr_idx;
    logic [15:0]   lfsr;
    logic [12:0]   lfsr_unused;
    logic          in_draw, refill, fallback, cand_ok, accept, lfsr_step, push, pop;
    logic [2:0]    cand, pick;

    tetris_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .step       (lfsr_step),
        .load       (seed_load),
        .load_value (seed),
        .state      (lfsr)
    );

    assign lfsr_unused = lfsr[15:3];
    assign cand        = lfsr[2:0];
    assign in_draw     = (state == BAG_DRAW);
    assign push        = (state == BAG_PUSH);
    assign refill      = in_draw && (mask == 7'd0);
    assign fallback    = (rej_cnt == RW'(MAX_REJECTS));
    assign cand_ok     = (cand != 3'd7) && mask[cand];
    assign accept      = in_draw && !refill && (fallback || cand_ok);
    assign pick        = fallback ? lowest_set(mask) : cand;
    // The refill cycle leaves the LFSR alone; every other draw cycle consumes one step.
    assign lfsr_step   = in_draw && !refill;
    assign pop         = piece_valid && piece_ready;
    assign count_nx    = count + {3'd0, push} - {3'd0, pop};
    assign wr_idx      = pop ? (count - 4'd1) : count;

    always_comb begin
        state_nx = state;
        case (state)
            BAG_IDLE: if (enable && (count != DEPTH4)) state_nx = BAG_DRAW;
            BAG_DRAW: if (accept) state_nx = BAG_PUSH;
            BAG_PUSH: state_nx = (enable && (count_nx < DEPTH4)) ? BAG_DRAW : BAG_IDLE;
            default:  state_nx = BAG_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET || seed_load) state <= BAG_IDLE;
        else                     state <= state_nx;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET || seed_load) begin
            mask       <= 7'd0;
            rej_cnt    <= '0;
            latched_id <= 3'd0;
        end else if (refill) begin
            mask <= 7'h7F;
        end else if (accept) begin
            mask       <= mask & ~(7'd1 << pick);
            rej_cnt    <= '0;
            latched_id <= pick;
        end else if (in_draw) begin
            rej_cnt <= rej_cnt + RW'(1);
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET)                     irq <= 1'b0;
        else if (refill && !seed_load)  irq <= 1'b1;
        else if (irq_ack)               irq <= 1'b0;
    end

    // Shift on pop first, then drop the new piece into the (possibly shifted) tail slot.
    always_comb begin
        for (int k = 0; k < PREVIEW_DEPTH; k++) q_nx[k] = q[k];
        if (pop) begin
            for (int k = 0; k < PREVIEW_DEPTH - 1; k++) q_nx[k] = q[k+1];
            q_nx[PREVIEW_DEPTH-1] = 3'd0;
        end
        if (push) begin
            for (int k = 0; k < PREVIEW_DEPTH; k++) begin
                if (4'(k) == wr_idx) q_nx[k] = latched_id;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET || seed_load) begin
            for (int k = 0; k < PREVIEW_DEPTH; k++) q[k] <= 3'd0;
            count <= 4'd0;
        end else begin
            q     <= q_nx;
            count <= count_nx;
        end
    end

    always_comb begin
        preview = '0;
        for (int k = 0; k < PREVIEW_DEPTH; k++) preview[3*k +: 3] = q[k];
    end

    assign preview_count = count;
    assign piece_id      = q[0];
    assign piece_valid   = (count != 4'd0);
    assign bag_remaining = popcount7(mask);

endmodule

// File: tb/tb_tetris_bag_scheduler.sv
// tb/tb_tetris_bag_scheduler.sv - self-checking bench for tetris_bag_scheduler
module tb_tetris_bag_scheduler;

    localparam int          PD        = 4;
    localparam int          MAXR      = 8;
    localparam logic [15:0] SEED0     = 16'hACE1;
    localparam int          MODEL_LEN = 400;

    logic          ACLK = 1'b0;
    logic          ARESET, enable, seed_load, piece_ready, irq_ack;
    logic [15:0]   seed;
    logic          piece_valid, irq;
    logic [2:0]    piece_id, bag_remaining;
    logic [3*PD-1:0] preview;
    logic [3:0]    preview_count;

    tetris_bag_scheduler #(.PREVIEW_DEPTH(PD), .LFSR_SEED(SEED0), .MAX_REJECTS(MAXR)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .enable(enable), .seed_load(seed_load), .seed(seed),
        .piece_valid(piece_valid), .piece_ready(piece_ready), .piece_id(piece_id),
        .preview(preview), .preview_count(preview_count), .bag_remaining(bag_remaining),
        .irq(irq), .irq_ack(irq_ack)
    );

    always #5 ACLK = ~ACLK;

    int n_pass = 0, n_checks = 0;
    int seq_id[$], seq_dc[$];
    bit seq_fb[$];
    int popped_ids[$], pop_gaps[$];
    int popped, cycle, last_pop_cyc, irq_rises, bagbits;
    bit timed, auto_ack;
    logic irq_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int exp_bag(input int drawn);
        return (drawn % 7 == 0) ? 0 : 7 - (drawn % 7);
    endfunction

    // Piece sequence is a pure function of the seed: stalls never advance the LFSR.
    task automatic gen_model(input logic [15:0] sd);
        logic [15:0] l;
        bit avail[7];
        int left, rej, pick, dc, cand;
        bit fb;
        l = (sd == 16'h0) ? SEED0 : sd;
        seq_id.delete(); seq_dc.delete(); seq_fb.delete();
        left = 0; rej = 0;
        for (int i = 0; i < MODEL_LEN; i++) begin
            dc = 0; fb = 0; pick = -1;
            if (left == 0) begin
                for (int j = 0; j < 7; j++) avail[j] = 1;
                left = 7; dc++;
            end
            while (pick < 0) begin
                dc++;
                cand = int'(l[2:0]);
                l = lfsr_next(l);
                if (rej == MAXR) begin
                    for (int j = 6; j >= 0; j--) if (avail[j]) pick = j;
                    fb = 1;
                end else if (cand < 7 && avail[cand]) begin
                    pick = cand;
                end else begin
                    rej++;
                end
            end
            avail[pick] = 0; left--; rej = 0;
            seq_id.push_back(pick); seq_dc.push_back(dc); seq_fb.push_back(fb);
        end
    endtask

    task automatic check_queue();
        logic [3*PD-1:0] exp_prev;
        exp_prev = '0;
        for (int k = 0; k < PD; k++) begin
            if (k < int'(preview_count) && popped + k < seq_id.size())
                exp_prev[3*k +: 3] = 3'(seq_id[popped+k]);
        end
        chk("preview", preview, exp_prev);
        chk("head", {piece_valid, piece_id}, {preview_count != 4'd0, exp_prev[2:0]});
    endtask

    task automatic cyc();
        bit pop, sl, rst;
        logic [15:0] sv;
        pop = piece_valid && piece_ready && !seed_load && !ARESET;
        sl = seed_load; sv = seed; rst = ARESET;
        if (pop) begin
            if (popped < seq_id.size()) chk("pop_id", piece_id, seq_id[popped]);
            if (timed && popped > 0) chk("pop_interval", cycle - last_pop_cyc, seq_dc[popped] + 1);
            pop_gaps.push_back(popped > 0 ? cycle - last_pop_cyc : 0);
            last_pop_cyc = cycle;
            popped_ids.push_back(int'(piece_id));
            bagbits |= (1 << piece_id);
        end
        @(posedge ACLK);
        @(negedge ACLK);
        cycle++;
        if (pop) begin
            popped++;
            if (popped % 7 == 0) begin
                chk("bag_group", bagbits, 32'h7F);
                bagbits = 0;
            end
        end
        if (rst || sl) begin
            gen_model(rst ? SEED0 : sv);
            popped = 0; bagbits = 0;
            popped_ids.delete(); pop_gaps.delete();
        end
        if (irq && !irq_prev) irq_rises++;
        irq_prev = irq;
        if (auto_ack) irq_ack = irq;
        check_queue();
    endtask

    task automatic wait_pops(input int n, input int budget);
        int c;
        c = 0;
        while (popped < n && c < budget) begin cyc(); c++; end
        chk("pops_reached", popped >= n, 1);
    endtask

    initial begin
        int n, dc4, fi, exp_low, rec[20];
        logic [15:0] s;
        bit found;

        ARESET = 1; enable = 0; seed_load = 0; seed = 16'h0; piece_ready = 0; irq_ack = 0;
        timed = 0; auto_ack = 0; popped = 0; cycle = 0; last_pop_cyc = 0; irq_rises = 0;
        bagbits = 0; irq_prev = 0;
        gen_model(SEED0);
        repeat (3) cyc();
        ARESET = 0;
        chk("rst_valid", piece_valid, 0);
        chk("rst_id", piece_id, 0);
        chk("rst_preview", preview, 0);
        chk("rst_count", preview_count, 0);
        chk("rst_bag", bag_remaining, 0);
        chk("rst_irq", irq, 0);

        // Fill the preview queue from reset
        enable = 1;
        n = 0;
        while (preview_count != 4'd4 && n < 4 * (MAXR + 3) + 1) begin cyc(); n++; end
        chk("fill_count", preview_count, 4);
        chk("fill_irq", irq, 1);
        chk("fill_bag", bag_remaining, 3);
        chk("fill_in_time", n <= 4 * (MAXR + 3) + 1, 1);

        // Pop once, then pop again exactly on the edge that pushes the refill piece
        dc4 = seq_dc[4];
        piece_ready = 1; cyc(); piece_ready = 0;
        repeat (dc4 + 1) cyc();
        chk("pp_count_before", preview_count, 3);
        piece_ready = 1; cyc(); piece_ready = 0;
        chk("pp_count_after", preview_count, 3);
        chk("pp_head", piece_id, seq_id[2]);
        chk("pp_tail", preview[8:6], seq_id[4]);
        n = 0;
        while (preview_count != 4'd4 && n < 30) begin cyc(); n++; end
        chk("refull_count", preview_count, 4);
        chk("refull_bag", bag_remaining, exp_bag(popped + int'(preview_count)));
        irq_ack = 1; cyc(); irq_ack = 0;
        chk("irq_ack_clear", irq, 0);

        // 70 back-to-back pops from seed 1234, auto-acking every refill
        enable = 0; repeat (MAXR + 4) cyc();
        irq_rises = 0; auto_ack = 1;
        seed = 16'h1234; seed_load = 1; enable = 1; piece_ready = 1; cyc(); seed_load = 0;
        timed = 1;
        wait_pops(70, 1000);
        for (int i = 0; i < 20; i++) rec[i] = (i < popped_ids.size()) ? popped_ids[i] : -1;
        enable = 0; piece_ready = 0; timed = 0;
        repeat (MAXR + 4) cyc();
        chk("irq_per_bag", irq_rises, (popped + int'(preview_count) + 6) / 7);
        chk("bag_after70", bag_remaining, exp_bag(popped + int'(preview_count)));
        auto_ack = 0; irq_ack = 0;

        // Reloading the same seed repeats the sequence; a zero seed behaves like LFSR_SEED
        seed = 16'h1234; seed_load = 1; enable = 1; piece_ready = 1; cyc(); seed_load = 0;
        timed = 1;
        wait_pops(20, 400);
        for (int i = 0; i < 20; i++)
            chk("repeat_seq", (i < popped_ids.size()) ? popped_ids[i] : -1, rec[i]);
        seed = 16'h0000; seed_load = 1; cyc(); seed_load = 0;
        wait_pops(20, 400);
        timed = 0;

        // Pick a seed whose early sequence contains a fallback pick mid-bag
        found = 0; fi = 0; exp_low = 0; s = 16'h0;
        for (int t = 0; t < 2000 && !found; t++) begin
            s = 16'($urandom);
            if (s != 16'h0) begin
                gen_model(s);
                for (int i = 1; i < 30 && !found; i++)
                    if (seq_fb[i] && (i % 7) != 0) begin found = 1; fi = i; end
            end
        end
        chk("fb_seed_found", found, 1);
        if (found) begin
            bagbits = 0;
            for (int j = fi - (fi % 7); j < fi; j++) bagbits |= (1 << seq_id[j]);
            for (int j = 6; j >= 0; j--) if (((bagbits >> j) & 1) == 0) exp_low = j;
            bagbits = 0;
            seed = s; seed_load = 1; piece_ready = 1; enable = 1; cyc(); seed_load = 0;
            timed = 1;
            wait_pops(fi + 1, 600);
            timed = 0;
            if (popped > fi) begin
                chk("fb_lowest_id", popped_ids[fi], exp_low);
                chk("fb_draw_cycles", pop_gaps[fi] - 1, MAXR + 1);
            end
        end

        // Random consumer, enable, ack and occasional reseed
        for (int i = 0; i < 400; i++) begin
            piece_ready = 1'($urandom_range(0, 1));
            enable      = ($urandom_range(0, 7) != 0);
            irq_ack     = ($urandom_range(0, 3) == 0);
            seed_load   = ($urandom_range(0, 63) == 0);
            seed        = 16'($urandom);
            cyc();
        end
        seed_load = 0; irq_ack = 0; piece_ready = 0; enable = 0;
        repeat (MAXR + 4) cyc();

        // irq_ack coinciding with a refill: the set wins
        seed = 16'h5A5A; seed_load = 1; enable = 1; cyc(); seed_load = 0;
        irq_ack = 1;
        cyc(); cyc();
        chk("irq_set_wins", irq, 1);
        cyc();
        chk("irq_ack_after", irq, 0);
        irq_ack = 0;

        // Reset with a piece in flight
        ARESET = 1; cyc(); ARESET = 0;
        chk("mid_rst_valid", piece_valid, 0);
        chk("mid_rst_id", piece_id, 0);
        chk("mid_rst_preview", preview, 0);
        chk("mid_rst_count", preview_count, 0);
        chk("mid_rst_bag", bag_remaining, 0);
        chk("mid_rst_irq", irq, 0);
        piece_ready = 1; timed = 1;
        wait_pops(14, 300);
        timed = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
